// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged per-domain reset release with soft and debounced button requests
module reset_sequencer #(
  parameter int NUM_STAGES      = 3,
  parameter int MIN_PULSE       = 8,
  parameter int STAGE_GAP       = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  button_n,
  input  logic                  soft_req,
  output logic [NUM_STAGES-1:0] reset_out,
  output logic                  ready
);

  localparam int                    IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [15:0]           PULSE_LAST = 16'(MIN_PULSE - 1);
  localparam logic [15:0]           GAP_LAST   = 16'(STAGE_GAP - 1);
  localparam logic [15:0]           DB_LAST    = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]           DB_FULL    = 16'(DEBOUNCE_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_STAGES - 1);
  localparam logic [IDX_W-1:0]      IDX_FIRST  = IDX_W'(1);
  localparam logic [NUM_STAGES-1:0] ALL_ON     = {NUM_STAGES{1'b1}};
  localparam logic [NUM_STAGES-1:0] STAGE_ONE  = NUM_STAGES'(1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  // Button synchronizer and debouncer
  logic        r_btn_meta;
  logic        r_btn_sync;
  logic [15:0] r_low_cnt;
  logic [15:0] r_high_cnt;
  logic        r_pressed;
  logic        r_press;

  // Sequencer state
  state_t                  r_state;
  logic [15:0]             r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [NUM_STAGES-1:0]   r_reset_out;
  logic                    r_ready;

  state_t                  w_state_nxt;
  logic [15:0]             w_cnt_nxt;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [NUM_STAGES-1:0]   w_reset_out_nxt;
  logic                    w_ready_nxt;
  logic                    w_request;

  // Two-flop synchronizer; idles high so leaving reset never looks like a press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_meta <= 1'b1;
      r_btn_sync <= 1'b1;
    end else begin
      r_btn_meta <= button_n;
      r_btn_sync <= r_btn_meta;
    end
  end

  // Debounce: one press pulse per held low run, re-armed only by a debounced release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_low_cnt  <= '0;
      r_high_cnt <= '0;
      r_pressed  <= 1'b0;
      r_press    <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (!r_btn_sync) begin
        r_high_cnt <= '0;
        if (r_low_cnt != DB_FULL) begin
          r_low_cnt <= r_low_cnt + 16'd1;
        end
        if (r_low_cnt == DB_LAST && !r_pressed) begin
          r_press   <= 1'b1;
          r_pressed <= 1'b1;
        end
      end else begin
        r_low_cnt <= '0;
        if (r_high_cnt != DB_FULL) begin
          r_high_cnt <= r_high_cnt + 16'd1;
        end
        if (r_high_cnt == DB_LAST) begin
          r_pressed <= 1'b0;
        end
      end
    end
  end

  // A soft request and a press landing on the same edge collapse into one restart
  assign w_request = soft_req | r_press;

  // Sequencer registers: state, counters and the registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_HOLD;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_reset_out <= ALL_ON;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_reset_out <= w_reset_out_nxt;
      r_ready     <= w_ready_nxt;
    end
  end

  // Next-state: hold all stages, then drop them one per gap in ascending order
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_reset_out_nxt = r_reset_out;
    w_ready_nxt     = r_ready;
    if (w_request) begin
      w_state_nxt     = S_HOLD;
      w_cnt_nxt       = '0;
      w_idx_nxt       = '0;
      w_reset_out_nxt = ALL_ON;
      w_ready_nxt     = 1'b0;
    end else begin
      unique case (r_state)
        S_HOLD: begin
          if (r_cnt == PULSE_LAST) begin
            w_reset_out_nxt[0] = 1'b0;
            w_cnt_nxt          = '0;
            if (NUM_STAGES == 1) begin
              w_state_nxt = S_RUN;
              w_ready_nxt = 1'b1;
            end else begin
              w_idx_nxt   = IDX_FIRST;
              w_state_nxt = S_RELEASE;
            end
          end else begin
            w_cnt_nxt = r_cnt + 16'd1;
          end
        end
        S_RELEASE: begin
          if (r_cnt == GAP_LAST) begin
            w_reset_out_nxt = r_reset_out & ~(STAGE_ONE << r_idx);
            w_cnt_nxt       = '0;
            if (r_idx == IDX_LAST) begin
              w_state_nxt = S_RUN;
              w_ready_nxt = 1'b1;
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + 16'd1;
          end
        end
        S_RUN: begin
          w_reset_out_nxt = '0;
          w_ready_nxt     = 1'b1;
        end
        default: begin
          w_state_nxt = S_HOLD;
        end
      endcase
    end
  end

  assign reset_out = r_reset_out;
  assign ready     = r_ready;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - randomized bench for reset_sequencer against an edge-count reference model
module tb_reset_sequencer;

  localparam int NS = 3;
  localparam int MP = 8;
  localparam int SG = 4;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          button_n;
  logic          soft_req;
  logic [NS-1:0] reset_out;
  logic          ready;

  int tests = 0;
  int fails = 0;

  // Reference model: edge count since reset fall, edge of the latest request, button run lengths
  int n;
  int start;
  int low_run;
  int high_run;
  bit armed;
  bit press_prev;
  bit h1;
  bit h2;

  int ready_falls;
  bit prev_ready;
  int e;
  bit rb;
  int seg;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_STAGES(NS),
    .MIN_PULSE(MP),
    .STAGE_GAP(SG),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button_n(button_n),
    .soft_req(soft_req),
    .reset_out(reset_out),
    .ready(ready)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  // Stage k is released once MIN_PULSE + k*STAGE_GAP edges have passed since the sequence start
  function automatic logic [NS-1:0] exp_out();
    logic [NS-1:0] r;
    for (int k = 0; k < NS; k++) begin
      r[k] = ((n - start) < (MP + k * SG));
    end
    return r;
  endfunction

  function automatic logic exp_ready();
    return ((n - start) >= (MP + (NS - 1) * SG));
  endfunction

  task automatic model_reset();
    n          = 0;
    start      = 0;
    low_run    = 0;
    high_run   = 0;
    armed      = 1'b1;
    press_prev = 1'b0;
    h1         = 1'b1;
    h2         = 1'b1;
    prev_ready = 1'b0;
  endtask

  task automatic model_edge(input bit sreq, input bit btn);
    bit press_now;
    bit seen;
    press_now = 1'b0;
    n++;
    seen = h2;
    h2   = h1;
    h1   = btn;
    if (!seen) begin
      high_run = 0;
      low_run++;
      if (low_run == DB && armed) begin
        press_now = 1'b1;
        armed     = 1'b0;
      end
    end else begin
      low_run = 0;
      high_run++;
      if (high_run >= DB) armed = 1'b1;
    end
    if (sreq || press_prev) start = n;
    press_prev = press_now;
  endtask

  task automatic cycle(input bit sreq, input bit btn);
    soft_req = sreq;
    button_n = btn;
    @(posedge clk);
    model_edge(sreq, btn);
    @(negedge clk);
    check_val("reset_out", reset_out, exp_out());
    check_val("ready", ready, exp_ready());
    if (prev_ready && !ready) ready_falls++;
    prev_ready = ready;
  endtask

  // Assert reset between edges, confirm outputs respond without a clock, then release at a negedge
  task automatic hit_reset();
    #2;
    reset    = 1'b1;
    soft_req = 1'b0;
    button_n = 1'b1;
    #1;
    check_val("async_out", reset_out, {NS{1'b1}});
    check_val("async_ready", ready, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset    = 1'b1;
    button_n = 1'b1;
    soft_req = 1'b0;
    ready_falls = 0;
    model_reset();
    #1;
    check_val("por_out", reset_out, 3'b111);
    check_val("por_ready", ready, 0);
    #19;
    reset = 1'b0;

    // Power-up schedule
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1);
      if (n == 7)  check_val("pu_e7", reset_out, 3'b111);
      if (n == 8)  check_val("pu_e8", reset_out, 3'b110);
      if (n == 12) check_val("pu_e12", reset_out, 3'b100);
      if (n == 16) check_val("pu_e16", {ready, reset_out}, 4'b1000);
    end

    // Soft request from RUN
    e = n + 1;
    cycle(1'b1, 1'b1);
    check_val("sreq_e", {ready, reset_out}, 4'b0111);
    for (int i = 0; i < 18; i++) begin
      cycle(1'b0, 1'b1);
      if (n == e + 8)  check_val("sreq_e8", reset_out, 3'b110);
      if (n == e + 12) check_val("sreq_e12", reset_out, 3'b100);
      if (n == e + 16) check_val("sreq_e16", {ready, reset_out}, 4'b1000);
    end

    // Button pressed for 10 cycles
    e = n + 1;
    ready_falls = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, (i < 10) ? 1'b0 : 1'b1);
      if (n == e + 5) check_val("btn_e5", reset_out, 3'b000);
      if (n == e + 6) check_val("btn_e6", reset_out, 3'b111);
    end
    check_val("btn_one_event", ready_falls, 1);

    // Short glitch: no restart
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, (i < 3) ? 1'b0 : 1'b1);
      check_val("glitch_ready", ready, 1);
    end

    // Held press, 2-cycle release, press again: one event only
    ready_falls = 0;
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0);
    for (int i = 0; i < 2; i++)  cycle(1'b0, 1'b1);
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0);
    check_val("held_short_rel", ready_falls, 1);
    // Debounced release, then a new press triggers again
    for (int i = 0; i < 6; i++)  cycle(1'b0, 1'b1);
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0);
    check_val("held_long_rel", ready_falls, 2);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);

    // Soft request at edge 10, inside RELEASE
    hit_reset();
    for (int i = 0; i < 22; i++) begin
      cycle((n + 1) == 10, 1'b1);
      if (n == 9)  check_val("mid_e9", reset_out, 3'b110);
      if (n == 10) check_val("mid_e10", reset_out, 3'b111);
      if (n == 17) check_val("mid_e17", reset_out, 3'b111);
      if (n == 18) check_val("mid_e18", reset_out, 3'b110);
    end

    // Async reset between edges 13 and 14
    hit_reset();
    for (int i = 0; i < 13; i++) cycle(1'b0, 1'b1);
    check_val("pre_async", reset_out, 3'b100);
    hit_reset();
    for (int i = 0; i < 18; i++) begin
      cycle(1'b0, 1'b1);
      if (n == 8)  check_val("re_e8", reset_out, 3'b110);
      if (n == 12) check_val("re_e12", reset_out, 3'b100);
      if (n == 16) check_val("re_e16", {ready, reset_out}, 4'b1000);
    end

    // Randomized mix of soft requests, button runs and occasional async resets
    rb  = 1'b1;
    seg = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        rb  = ~rb;
        seg = rb ? $urandom_range(1, 12) : $urandom_range(1, 10);
      end
      seg--;
      if ($urandom_range(0, 499) == 0) hit_reset();
      cycle($urandom_range(0, 59) == 0, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Reset sequencer that sits downstream of the reset synchronizer and fans one reset into staged, per-domain resets. It holds every stage in reset for a guaranteed minimum width, then releases the stages one at a time in index order with a fixed gap between releases. It also re-enters reset on a software request or on a debounced, active-low push-button press. All outputs are registered in a single clock domain.

## Interface
- NUM_STAGES, 3, number of reset outputs (1..8)
- MIN_PULSE, 8, cycles all stages stay asserted before stage 0 releases (1..65535)
- STAGE_GAP, 4, cycles between consecutive stage releases (1..65535)
- DEBOUNCE_CYCLES, 4, consecutive low samples required to accept a button press (1..65535)

- clk  input  1  system clock; one clock for the whole block
- reset  input  1  asynchronous, active-high reset
- button_n  input  1  raw push-button, active-low, asynchronous to clk
- soft_req  input  1  synchronous reset-request pulse, active-high
- reset_out  output  NUM_STAGES  per-stage reset, active-high; bit 0 releases first
- ready  output  1  high once all stages are released (state RUN)

## Operation
- States: HOLD, RELEASE, RUN. 16-bit counter cnt. Stage index idx.
- reset=1, asynchronous: state=HOLD, cnt=0, idx=0, reset_out=all ones, ready=0, debounce logic cleared, press latch cleared.
- HOLD: cnt increments each edge. At the edge where cnt==MIN_PULSE-1:
  - reset_out[0] is cleared.
  - If NUM_STAGES==1, go to RUN and set ready.
  - Otherwise set idx=1, cnt=0, and go to RELEASE.
- RELEASE: cnt increments each edge. At the edge where cnt==STAGE_GAP-1:
  - reset_out[idx] is cleared and cnt=0.
  - If idx==NUM_STAGES-1, go to RUN and set ready=1 on that same edge.
  - Otherwise idx increments.
- RUN: outputs are static (reset_out=0, ready=1) until a request arrives.
- Request = soft_req high at an edge, OR the press event from the debouncer.
  - A request in any state forces reset_out=all ones, ready=0, cnt=0, idx=0, and state HOLD at that edge.
  - A request during HOLD or RELEASE restarts the sequence from scratch.
- Button path:
  - Two-flop synchronizer on button_n.
  - The debounce counter counts consecutive synchronized-low samples and clears on any high sample.
  - The press event fires once when the count reaches DEBOUNCE_CYCLES. The count then saturates, so a held button produces exactly one event.
  - The next event is possible only after DEBOUNCE_CYCLES consecutive synchronized-high samples (release debounced).
- Once released, a stage stays released until the next request or reset. Release order is strictly ascending.

## Timing
- Edge numbering: edge 1 is the first rising clk edge after reset falls.
- Stage release, measured from reset fall:
  - reset_out[k] falls at edge MIN_PULSE + k*STAGE_GAP.
  - ready rises at edge MIN_PULSE + (NUM_STAGES-1)*STAGE_GAP.
  - Defaults: stage 0 at edge 8, stage 1 at edge 12, stage 2 at edge 16, ready at edge 16.
- Stage release, measured from a soft_req sampled at edge e: same schedule with edge e replacing edge 0. Example: stage 0 at e+8.
- Button latency: button_n held low and stable from just before edge e gives reset_out=all ones at edge e+2+DEBOUNCE_CYCLES (default e+6).
- Button glitch: a low pulse shorter than DEBOUNCE_CYCLES synchronized samples produces no event.
- soft_req and press event on the same edge: treated as one request.
- reset asserted mid-sequence: outputs go all ones immediately without waiting for clk. The full schedule restarts after deassertion.
- Minimum assertion width of every stage is at least MIN_PULSE cycles, regardless of request timing.

## Test plan
- Power-up, defaults: reset high 20 ns, then low → reset_out=111 during reset; 110 at edge 8, 100 at edge 12, 000 and ready=1 at edge 16.
- soft_req pulse in RUN at edge e → reset_out=111 and ready=0 at edge e; stages release at e+8, e+12, e+16.
- button_n low for 10 cycles from edge e → reset_out=111 at e+6; exactly one restart occurs. A 3-cycle low glitch produces no change.
- Held button, then release and press again:
  - Only one event while held.
  - A second press after ≥4 high cycles triggers again.
  - A second press after only 2 high cycles does not.
- soft_req at edge 10, which falls in RELEASE with reset_out=110 → reset_out=111 at edge 10; stage 0 re-releases at edge 18, not earlier.
- reset asserted between edges 13 and 14 (reset_out=100) → reset_out=111 immediately, ready=0; after deassertion the full 8/12/16 schedule repeats.
